// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences MAR/MDR strobes for one read or write request at a time
module mem_access_seq #(
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              ld_mar,
  output logic              ld_mdr,
  output logic              sel_mdr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mdr_in
);
  typedef enum logic [2:0] {IDLE, MAR, WAIT, MDR, CAPT, WR, RESP} state_t;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic rw_q, rw_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  assign rdata = rdata_q;
  // state and request registers; reset discards any in-flight request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // next state and strobes, decoded purely from state so reset drops them at once
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready     = 1'b0;
    done      = 1'b0;
    bus_out   = '0;
    bus_drive = 1'b0;
    ld_mar    = 1'b0;
    ld_mdr    = 1'b0;
    sel_mdr   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          rw_d    = rw;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = MAR;
        end
      end
      MAR: begin
        bus_drive = 1'b1;
        bus_out   = addr_q;
        ld_mar    = 1'b1;
        state_d   = (!rw_q && WAIT_CYCLES > 0) ? WAIT : MDR;
        cnt_d     = WAIT_INIT;
      end
      WAIT: begin
        cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? MDR : WAIT;
      end
      MDR: begin
        ld_mdr    = 1'b1;
        sel_mdr   = !rw_q;
        bus_drive = rw_q;
        bus_out   = rw_q ? wdata_q : '0;
        state_d   = rw_q ? WR : CAPT;
      end
      CAPT: begin
        rdata_d = mdr_in;
        state_d = RESP;
      end
      WR: begin
        mem_we  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed bench with a MAR/MDR memory model and a read-data scoreboard
module tb_mem_access_seq;
  logic clk, reset;
  logic req0, rw0, ready0, done0, bus_drive0, ld_mar0, ld_mdr0, sel_mdr0, mem_we0;
  logic [15:0] addr0, wdata0, rdata0, bus_out0, mdr0, mar0;
  logic req1, rw1, ready1, done1, bus_drive1, ld_mar1, ld_mdr1, sel_mdr1, mem_we1;
  logic [15:0] addr1, wdata1, rdata1, bus_out1, mdr1, mar1;
  logic [15:0] mem0 [0:15];
  logic [15:0] mem1 [0:15];
  logic [15:0] ref0 [0:15];
  logic [15:0] q0 [$];
  logic [15:0] exp0;
  int checks, failures, dcnt0, we_cnt0, d_base, w_base;

  mem_access_seq #(.DATA_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .rw(rw0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .done(done0), .rdata(rdata0), .bus_out(bus_out0), .bus_drive(bus_drive0),
    .ld_mar(ld_mar0), .ld_mdr(ld_mdr0), .sel_mdr(sel_mdr0), .mem_we(mem_we0), .mdr_in(mdr0));

  mem_access_seq #(.DATA_W(16), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .rw(rw1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .done(done1), .rdata(rdata1), .bus_out(bus_out1), .bus_drive(bus_drive1),
    .ld_mar(ld_mar1), .ld_mdr(ld_mdr1), .sel_mdr(sel_mdr1), .mem_we(mem_we1), .mdr_in(mdr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory block models: MAR, MDR and a 16-entry array per DUT
  always @(posedge clk) begin
    if (ld_mar0) mar0 <= bus_out0;
    if (ld_mdr0) mdr0 <= sel_mdr0 ? mem0[mar0[3:0]] : bus_out0;
    if (mem_we0) begin
      mem0[mar0[3:0]] <= mdr0;
      we_cnt0 <= we_cnt0 + 1;
    end
    if (ld_mar1) mar1 <= bus_out1;
    if (ld_mdr1) mdr1 <= sel_mdr1 ? mem1[mar1[3:0]] : bus_out1;
    if (mem_we1) mem1[mar1[3:0]] <= mdr1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // strobe invariants and scoreboard pop on every completion
  always @(negedge clk) begin
    if (!reset) begin
      chk("strobe_excl", 32'(ld_mar0) + 32'(ld_mdr0) + 32'(mem_we0) > 1, 0);
      chk("drive_vs_sel", bus_drive0 & sel_mdr0, 0);
      chk("bus_idle_zero", bus_drive0 ? 16'h0 : bus_out0, 0);
      if (done0) begin
        dcnt0 <= dcnt0 + 1;
        chk("sb_depth", q0.size(), 1);
        if (q0.size() > 0) chk("sb_rdata", rdata0, q0.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start0(input bit rw, input logic [15:0] a, input logic [15:0] d);
    req0 = 1'b1;
    rw0 = rw;
    addr0 = a;
    wdata0 = d;
    if (rw) ref0[a[3:0]] = d;
    else exp0 = ref0[a[3:0]];
    q0.push_back(exp0);
    tick();
  endtask

  task automatic xact0(input bit rw, input logic [15:0] a, input logic [15:0] d);
    start0(rw, a, d);
    req0 = 1'b0;
    chk("t1_ld_mar", ld_mar0, 1);
    chk("t1_bus", bus_out0, a);
    tick();
    chk("t2_ld_mdr", ld_mdr0, 1);
    chk("t2_sel_mdr", sel_mdr0, !rw);
    chk("t2_bus", bus_out0, rw ? d : 16'h0);
    tick();
    chk("t3_mem_we", mem_we0, rw);
    tick();
    chk("t4_done", done0, 1);
    tick();
    chk("t5_ready", ready0, 1);
  endtask

  task automatic rst_pulse();
    #1 reset = 1'b1;
    q0.delete();
    exp0 = '0;
    #1;
    chk("rst_ready", ready0, 1);
    chk("rst_strobes", {done0, ld_mar0, ld_mdr0, sel_mdr0, mem_we0, bus_drive0}, 0);
    chk("rst_bus", bus_out0, 0);
    chk("rst_rdata", rdata0, 0);
    #1 reset = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; dcnt0 = 0; we_cnt0 = 0; exp0 = '0;
    mar0 = '0; mdr0 = '0; mar1 = '0; mdr1 = '0;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
      ref0[i] = '0;
    end
    mem1[2] = 16'h1234;
    req0 = 0; rw0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; rw1 = 0; addr1 = '0; wdata1 = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("init_ready", ready0, 1);
    chk("init_strobes", {done0, ld_mar0, ld_mdr0, sel_mdr0, mem_we0, bus_drive0}, 0);
    chk("init_rdata", rdata0, 0);
    #10 reset = 1'b0;
    tick();
    xact0(1'b1, 16'h0005, 16'hBEEF);
    xact0(1'b0, 16'h0005, 16'h0000);
    chk("rd_rdata", rdata0, 16'hBEEF);
    req1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0002;
    tick();
    req1 = 1'b0;
    chk("w3_t1_ld_mar", ld_mar1, 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("w3_t%0d_quiet", i), {ld_mar1, ld_mdr1, sel_mdr1, mem_we1, bus_drive1, done1}, 0);
    end
    tick();
    chk("w3_t5_mdr", {ld_mdr1, sel_mdr1}, 2'b11);
    tick();
    chk("w3_t6_done", done1, 0);
    tick();
    chk("w3_t7_done", done1, 1);
    chk("w3_rdata", rdata1, 16'h1234);
    tick();
    d_base = dcnt0; w_base = we_cnt0;
    start0(1'b0, 16'h0005, 16'h0000);
    req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0009; wdata0 = 16'h1111;
    tick();
    tick();
    req0 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("ign_one_done", dcnt0 - d_base, 1);
    chk("ign_no_write", we_cnt0 - w_base, 0);
    start0(1'b0, 16'h0005, 16'h0000);
    req0 = 1'b0;
    rst_pulse();
    for (int i = 0; i < 6; i++) tick();
    d_base = dcnt0; w_base = we_cnt0;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0003; wdata0 = 16'hFFFF;
    tick();
    req0 = 1'b0;
    tick();
    chk("ab_t2_bus", bus_out0, 16'hFFFF);
    rst_pulse();
    for (int i = 0; i < 6; i++) tick();
    chk("ab_no_we", we_cnt0 - w_base, 0);
    chk("ab_no_done", dcnt0 - d_base, 0);
    xact0(1'b0, 16'h0003, 16'h0000);
    chk("ab_rdata", rdata0, 16'h0000);
    for (int e = 0; e < 5; e++) begin
      case (e)
        0: start0(1'b1, 16'h0001, 16'hAAAA);
        1: start0(1'b1, 16'h0002, 16'h5555);
        2: start0(1'b0, 16'h0001, 16'h0000);
        3: start0(1'b1, 16'h0002, 16'h5555);
        default: start0(1'b0, 16'h0002, 16'h0000);
      endcase
      if (e == 4) req0 = 1'b0;
      chk("b2b_accept", ld_mar0, 1);
      for (int t = 1; t <= 4; t++) begin
        chk($sformatf("b2b_busy_t%0d", t), ready0, 0);
        tick();
      end
      chk("b2b_ready_t5", ready0, 1);
      if (e == 3) chk("b2b_wr_keeps_rdata", rdata0, 16'hAAAA);
    end
    chk("b2b_final_rdata", rdata0, 16'h5555);
    chk("sb_drained", q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
